// File: rtl/iomem_seq.sv
// iomem_seq: table-driven iomem bus master running WRITE / FILL / DELAY / HALT programs.
// Define IOMEM_SEQ_VERIFY_EN to read back and compare every write issued.
module iomem_seq #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1024,
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    output logic [IW-1:0] tbl_addr,
    input  logic [79:0]   tbl_data,
    output logic          iomem_valid,
    input  logic          iomem_ready,
    output logic [3:0]    iomem_wstrb,
    output logic [31:0]   iomem_addr,
    output logic [31:0]   iomem_wdata,
    input  logic [31:0]   iomem_rdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_index
);

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

`ifdef IOMEM_SEQ_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_BUS, S_DELAY, S_DONE, S_ERROR, S_VERIFY
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_BUS, S_DELAY, S_DONE, S_ERROR
    } state_t;

    logic unused_rdata;
    assign unused_rdata = ^iomem_rdata;
`endif

    state_t        state;
    logic [IW-1:0] index;
    logic [11:0]   cnt_r;
    logic [31:0]   addr_r;
    logic [31:0]   data_r;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    run_sync;
    logic          run_en;
    logic          last_entry;

    assign tbl_addr   = index;
    assign run_en     = run_sync[1];
    assign last_entry = (index == LAST);

    // Reset assertion is immediate; release reaches the sequencer through two flops.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            run_sync <= 2'b00;
        end else begin
            run_sync <= {run_sync[0], 1'b1};
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            index       <= '0;
            cnt_r       <= '0;
            addr_r      <= '0;
            data_r      <= '0;
            tmo_cnt     <= '0;
            iomem_valid <= 1'b0;
            iomem_wstrb <= '0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_index   <= '0;
        end else if (run_en) begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state     <= S_FETCH;
                        index     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                    end
                end

                S_FETCH: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    addr_r <= tbl_data[63:32];
                    data_r <= tbl_data[31:0];
                    cnt_r  <= tbl_data[75:64];
                    case (tbl_data[79:76])
                        4'd0: begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        4'd1: begin
                            cnt_r <= 12'd1;
                            state <= S_BUS;
                        end
                        4'd2, 4'd3: begin
                            if (tbl_data[75:64] != 12'd0) begin
                                state <= (tbl_data[79:76] == 4'd2) ? S_BUS : S_DELAY;
                            end else if (last_entry) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                index <= index + 1'b1;
                                state <= S_FETCH;
                            end
                        end
                        default: begin
                            state     <= S_ERROR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_index <= index;
                        end
                    endcase
                end

                // A write is raised from a cycle with valid low, so back-to-back FILL beats get a gap.
                S_BUS: begin
                    if (!iomem_valid) begin
                        iomem_valid <= 1'b1;
                        iomem_wstrb <= 4'b1111;
                        iomem_addr  <= addr_r;
                        iomem_wdata <= data_r;
                        tmo_cnt     <= '0;
                    end else if (iomem_ready) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= '0;
                        iomem_addr  <= '0;
                        iomem_wdata <= '0;
`ifdef IOMEM_SEQ_VERIFY_EN
                        state       <= S_VERIFY;
`else
                        if (cnt_r > 12'd1) begin
                            cnt_r  <= cnt_r - 12'd1;
                            addr_r <= addr_r + 32'd4;
                        end else if (last_entry) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            state <= S_FETCH;
                        end
`endif
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= '0;
                        iomem_addr  <= '0;
                        iomem_wdata <= '0;
                        state       <= S_ERROR;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        err_index   <= index;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

`ifdef IOMEM_SEQ_VERIFY_EN
                S_VERIFY: begin
                    if (!iomem_valid) begin
                        iomem_valid <= 1'b1;
                        iomem_wstrb <= '0;
                        iomem_addr  <= addr_r;
                        iomem_wdata <= '0;
                        tmo_cnt     <= '0;
                    end else if (iomem_ready) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= '0;
                        iomem_addr  <= '0;
                        iomem_wdata <= '0;
                        if (iomem_rdata != data_r) begin
                            state     <= S_ERROR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_index <= index;
                        end else if (cnt_r > 12'd1) begin
                            cnt_r  <= cnt_r - 12'd1;
                            addr_r <= addr_r + 32'd4;
                            state  <= S_BUS;
                        end else if (last_entry) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            state <= S_FETCH;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= '0;
                        iomem_addr  <= '0;
                        iomem_wdata <= '0;
                        state       <= S_ERROR;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        err_index   <= index;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
`endif

                S_DELAY: begin
                    if (cnt_r > 12'd1) begin
                        cnt_r <= cnt_r - 12'd1;
                    end else if (last_entry) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        index <= index + 1'b1;
                        state <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_seq.sv
// Scoreboard bench for iomem_seq: expected bus transactions are queued by the
// stimulus and consumed by a monitor on every valid/ready handshake.
module tb_iomem_seq;

    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 16;
    localparam int IW      = 6;
`ifdef IOMEM_SEQ_VERIFY_EN
    localparam int WPR = 2;
`else
    localparam int WPR = 1;
`endif

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic          ck;
    logic          rst;
    logic          start;
    logic [IW-1:0] tbl_addr;
    logic [79:0]   tbl_data;
    logic          iomem_valid;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb;
    logic [31:0]   iomem_addr;
    logic [31:0]   iomem_wdata;
    logic [31:0]   iomem_rdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [IW-1:0] err_index;

    logic [79:0] tbl_mem [DEPTH];
    txn_t        exp_q [$];
    txn_t        exp_t;
    int          rise_times [$];
    int          checks;
    int          errors;
    int          cyc;
    int          hang_cycles;
    logic        prev_hs;
    logic        prev_valid;
    logic        hang_en;
    logic [31:0] hang_addr;
    logic        bad_en;
    logic [31:0] bad_addr;
    logic [31:0] last_wdata;

    iomem_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .ck          (ck),
        .rst         (rst),
        .start       (start),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_index   (err_index)
    );

    always #5 ck = ~ck;

    // Program table with one cycle of read latency.
    always @(posedge ck) begin
        tbl_data <= tbl_mem[tbl_addr];
    end

    // Slave answers one cycle after valid unless the address is being stalled.
    always @(posedge ck) begin
        if (iomem_valid && !iomem_ready && !(hang_en && iomem_addr == hang_addr)) begin
            iomem_ready <= 1'b1;
            if (iomem_wstrb != 4'h0) last_wdata <= iomem_wdata;
            iomem_rdata <= (bad_en && iomem_addr == bad_addr) ? 32'h0000_1234 : last_wdata;
        end else begin
            iomem_ready <= 1'b0;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks bus idle rules.
    always @(negedge ck) begin
        cyc = cyc + 1;
        if (!rst) begin
            prev_hs    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_hs) begin
                checks++;
                if (iomem_valid) begin
                    errors++;
                    $display("[TB] FAIL valid_drop: valid=%0b after handshake, required 0", iomem_valid);
                end
            end
            if (prev_valid && !iomem_valid) begin
                checks++;
                if ({iomem_wstrb, iomem_addr, iomem_wdata} != 68'h0) begin
                    errors++;
                    $display("[TB] FAIL idle_zero: wstrb=%h addr=%h wdata=%h, required all 0",
                             iomem_wstrb, iomem_addr, iomem_wdata);
                end
            end
            if (iomem_valid && !prev_valid) rise_times.push_back(cyc);
            if (iomem_valid && hang_en && iomem_addr == hang_addr) hang_cycles++;
            if (iomem_valid && iomem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_txn: wstrb=%h addr=%h wdata=%h, required none",
                             iomem_wstrb, iomem_addr, iomem_wdata);
                end else begin
                    exp_t = exp_q.pop_front();
                    if ({iomem_wstrb, iomem_addr, iomem_wdata} !== exp_t) begin
                        errors++;
                        $display("[TB] FAIL bus_txn: got wstrb=%h addr=%h wdata=%h, required wstrb=%h addr=%h wdata=%h",
                                 iomem_wstrb, iomem_addr, iomem_wdata, exp_t.wstrb, exp_t.addr, exp_t.data);
                    end
                end
            end
            prev_hs    = iomem_valid && iomem_ready;
            prev_valid = iomem_valid;
        end
    end

    function automatic logic [79:0] ent(input logic [3:0] op, input logic [11:0] cnt,
                                        input logic [31:0] a, input logic [31:0] d);
        return {op, cnt, a, d};
    endfunction

    task automatic clearTable();
        for (int i = 0; i < DEPTH; i++) tbl_mem[i] = 80'h0;
    endtask

    task automatic pushWrite(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({4'hf, a, d});
`ifdef IOMEM_SEQ_VERIFY_EN
        exp_q.push_back({4'h0, a, 32'h0});
`endif
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus();
        @(negedge ck);
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge ck);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait: no done/error within %0d cycles, required completion", name, budget);
        end
    endtask

    int d10;
    int d0;
    int rises_before;

    initial begin
        ck          = 1'b0;
        start       = 1'b0;
        hang_en     = 1'b0;
        hang_addr   = 32'h0;
        bad_en      = 1'b0;
        bad_addr    = 32'h0;
        last_wdata  = 32'h0;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        hang_cycles = 0;
        clearTable();

        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_valid", iomem_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_err_index", err_index, 0);
        checkOutput("rst_tbl_addr", tbl_addr, 0);
        checkOutput("rst_bus", {iomem_wstrb, iomem_addr[27:0]}, 0);
        repeat (2) @(negedge ck);
        rst = 1'b1;
        repeat (3) @(negedge ck);

        $display("[TB] two writes then halt");
        tbl_mem[0] = ent(4'd1, 12'd0, 32'h6000_0000, 32'h2000_ffff);
        tbl_mem[1] = ent(4'd1, 12'd0, 32'h6000_0004, 32'h8200_0001);
        pushWrite(32'h6000_0000, 32'h2000_ffff);
        pushWrite(32'h6000_0004, 32'h8200_0001);
        applyStimulus();
        checkOutput("run_busy", busy, 1);
        waitDone("write2", 500);
        checkOutput("write2_done", done, 1);
        checkOutput("write2_error", error, 0);
        checkOutput("write2_busy", busy, 0);
        checkOutput("write2_q", exp_q.size(), 0);

        $display("[TB] fill runs, address wrap, zero count, start while busy");
        clearTable();
        tbl_mem[0] = ent(4'd2, 12'd4, 32'h6400_0000, 32'h0000_aaaa);
        tbl_mem[1] = ent(4'd2, 12'd2, 32'hffff_fffc, 32'h0000_0055);
        tbl_mem[2] = ent(4'd2, 12'd0, 32'h6500_0000, 32'h0000_0077);
        for (int i = 0; i < 4; i++) pushWrite(32'h6400_0000 + 32'(4 * i), 32'h0000_aaaa);
        pushWrite(32'hffff_fffc, 32'h0000_0055);
        pushWrite(32'h0000_0000, 32'h0000_0055);
        applyStimulus();
        repeat (5) @(negedge ck);
        applyStimulus();
        waitDone("fill", 500);
        checkOutput("fill_done", done, 1);
        checkOutput("fill_error", error, 0);
        checkOutput("fill_q", exp_q.size(), 0);

        $display("[TB] delay spacing");
        clearTable();
        tbl_mem[0] = ent(4'd1, 12'd0, 32'h6100_0000, 32'h0000_0001);
        tbl_mem[1] = ent(4'd3, 12'd10, 32'h0, 32'h0);
        tbl_mem[2] = ent(4'd1, 12'd0, 32'h6100_0004, 32'h0000_0002);
        pushWrite(32'h6100_0000, 32'h0000_0001);
        pushWrite(32'h6100_0004, 32'h0000_0002);
        rise_times.delete();
        applyStimulus();
        waitDone("delay10", 500);
        d10 = (rise_times.size() > WPR) ? rise_times[WPR] - rise_times[0] : 0;
        tbl_mem[1] = ent(4'd3, 12'd0, 32'h0, 32'h0);
        pushWrite(32'h6100_0000, 32'h0000_0001);
        pushWrite(32'h6100_0004, 32'h0000_0002);
        rise_times.delete();
        applyStimulus();
        waitDone("delay0", 500);
        d0 = (rise_times.size() > WPR) ? rise_times[WPR] - rise_times[0] : 0;
        checkOutput("delay_span", d10 - d0, 10);
        checkOutput("delay_done", done, 1);
        checkOutput("delay_q", exp_q.size(), 0);

        $display("[TB] ready timeout on entry 3");
        clearTable();
        for (int i = 0; i < 4; i++) tbl_mem[i] = ent(4'd1, 12'd0, 32'h6000_00c0 - 32'(16 * (3 - i)), 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) pushWrite(32'h6000_00c0 - 32'(16 * (3 - i)), 32'h100 + 32'(i));
        hang_en     = 1'b1;
        hang_addr   = 32'h6000_00c0;
        hang_cycles = 0;
        applyStimulus();
        waitDone("timeout", 500);
        checkOutput("timeout_error", error, 1);
        checkOutput("timeout_err_index", err_index, 3);
        checkOutput("timeout_done", done, 0);
        checkOutput("timeout_valid_cycles", hang_cycles, TIMEOUT);
        rises_before = rise_times.size();
        repeat (30) @(negedge ck);
        checkOutput("timeout_quiet", rise_times.size(), rises_before);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_q", exp_q.size(), 0);
        hang_en = 1'b0;

        $display("[TB] illegal opcode");
        clearTable();
        tbl_mem[0] = ent(4'd1, 12'd0, 32'h6200_0000, 32'h0000_00aa);
        tbl_mem[1] = ent(4'd5, 12'd0, 32'h0, 32'h0);
        pushWrite(32'h6200_0000, 32'h0000_00aa);
        applyStimulus();
        waitDone("illegal", 500);
        checkOutput("illegal_error", error, 1);
        checkOutput("illegal_err_index", err_index, 1);
        checkOutput("illegal_q", exp_q.size(), 0);

        $display("[TB] reset during a write");
        clearTable();
        tbl_mem[0] = ent(4'd1, 12'd0, 32'h6300_0000, 32'h0000_0033);
        hang_en   = 1'b1;
        hang_addr = 32'h6300_0000;
        applyStimulus();
        for (int n = 0; n < 50 && !iomem_valid; n++) @(negedge ck);
        checkOutput("abort_valid_seen", iomem_valid, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_valid", iomem_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_addr", iomem_addr, 0);
        @(negedge ck);
        rst     = 1'b1;
        hang_en = 1'b0;
        rises_before = rise_times.size();
        repeat (6) @(negedge ck);
        checkOutput("abort_no_resume", rise_times.size(), rises_before);
        pushWrite(32'h6300_0000, 32'h0000_0033);
        applyStimulus();
        waitDone("rerun", 500);
        checkOutput("rerun_done", done, 1);
        checkOutput("rerun_q", exp_q.size(), 0);

        $display("[TB] implicit halt at end of table");
        for (int i = 0; i < DEPTH; i++) tbl_mem[i] = ent(4'd3, 12'd0, 32'h0, 32'h0);
        rises_before = rise_times.size();
        applyStimulus();
        waitDone("implicit", 1000);
        checkOutput("implicit_done", done, 1);
        checkOutput("implicit_error", error, 0);
        checkOutput("implicit_no_bus", rise_times.size(), rises_before);

`ifdef IOMEM_SEQ_VERIFY_EN
        $display("[TB] readback compare");
        clearTable();
        tbl_mem[0] = ent(4'd1, 12'd0, 32'h6600_0000, 32'h0000_0001);
        tbl_mem[1] = ent(4'd1, 12'd0, 32'h6600_0004, 32'h0000_0002);
        tbl_mem[2] = ent(4'd1, 12'd0, 32'h6600_0008, 32'h0000_1111);
        for (int i = 0; i < 3; i++) pushWrite(32'h6600_0000 + 32'(4 * i), (i == 2) ? 32'h1111 : 32'(i + 1));
        bad_en   = 1'b1;
        bad_addr = 32'h6600_0008;
        applyStimulus();
        waitDone("verify_bad", 500);
        checkOutput("verify_bad_error", error, 1);
        checkOutput("verify_bad_err_index", err_index, 2);
        checkOutput("verify_bad_q", exp_q.size(), 0);
        bad_en = 1'b0;
        for (int i = 0; i < 3; i++) pushWrite(32'h6600_0000 + 32'(4 * i), (i == 2) ? 32'h1111 : 32'(i + 1));
        applyStimulus();
        waitDone("verify_good", 500);
        checkOutput("verify_good_done", done, 1);
        checkOutput("verify_good_error", error, 0);
        checkOutput("verify_good_q", exp_q.size(), 0);
`endif

        repeat (3) @(negedge ck);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
